// File: rtl/prbs8_pkg.sv
// rtl/prbs8_pkg.sv - shared types and helpers for the PRBS8 checker
// Holds the checker FSM state encoding, the generator tap mask and the
// next-state / popcount helper functions used by the checker datapath.
package prbs8_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // x^8+x^6+x^5+x+1 in Galois form: feedback from stage 7 into stages 6,5,1,0.
    localparam logic [7:0] PRBS8_TAPS = 8'h63;

    // One step of the generator: shift toward stage 7, fold stage 7 back through the taps.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
        return {d[6:0], 1'b0} ^ (d[7] ? PRBS8_TAPS : 8'h00);
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs8_sat_cnt.sv
// rtl/prbs8_sat_cnt.sv - 16-bit saturating accumulator with clear
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear, wins over en
//   en         : add inc this cycle
//   inc[3:0]   : increment amount
//   cnt[15:0]  : accumulated value, sticks at 0xFFFF
module prbs8_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [3:0]  inc,
    output logic [15:0] cnt
);

    logic [16:0] sum;

    assign sum = {1'b0, cnt} + {13'd0, inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // A carry out of bit 15 means the true sum passed 0xFFFF: clamp.
            cnt <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

endmodule

// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - PRBS8 word checker with lock FSM and error counters
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : clears err_cnt and bit_err_cnt only
//   in_valid    : din carries a word this cycle
//   din[7:0]    : received generator state, din[i] = stage i
//   locked      : high while the FSM is LOCKED
//   err_pulse   : one-cycle pulse per mismatching word while locked
//   err_cnt     : saturating count of mismatching words
//   bit_err_cnt : saturating count of mismatching bits
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_ERR = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  din,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [15:0] bit_err_cnt
);

    localparam logic [4:0] LOCK_W   = 5'(LOCK_CNT);
    localparam logic [4:0] UNLOCK_W = 5'(UNLOCK_ERR);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] exp_word;
    logic [7:0] exp_nxt;
    logic [3:0] mcnt;
    logic [3:0] mcnt_nxt;
    logic [3:0] miss;
    logic [3:0] miss_nxt;
    logic       err_hit;
    logic       locked_nxt;
    logic       err_pulse_nxt;

    logic       mismatch;
    logic [7:0] din_step;
    logic [7:0] exp_step;
    logic [4:0] mcnt_inc;
    logic [4:0] miss_inc;
    logic [3:0] bit_errs;

    assign mismatch = (din != exp_word);
    assign din_step = lfsr8_next(din);
    assign exp_step = lfsr8_next(exp_word);
    assign mcnt_inc = {1'b0, mcnt} + 5'd1;
    assign miss_inc = {1'b0, miss} + 5'd1;
    assign bit_errs = popcount8(din ^ exp_word);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_SEARCH;
            exp_word  <= 8'h00;
            mcnt      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_word  <= exp_nxt;
            mcnt      <= mcnt_nxt;
            miss      <= miss_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_word;
        mcnt_nxt  = mcnt;
        miss_nxt  = miss;
        err_hit   = 1'b0;
        if (in_valid) begin
            case (state)
                ST_SEARCH: begin
                    // 0x00 is the generator lock-up word and can never seed.
                    if (din != 8'h00) begin
                        exp_nxt   = din_step;
                        mcnt_nxt  = '0;
                        state_nxt = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!mismatch) begin
                        exp_nxt  = din_step;
                        mcnt_nxt = mcnt_inc[3:0];
                        if (mcnt_inc == LOCK_W) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (din != 8'h00) begin
                        exp_nxt  = din_step;
                        mcnt_nxt = '0;
                    end else begin
                        mcnt_nxt  = '0;
                        state_nxt = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the local copy runs on its own, din only scores.
                    exp_nxt = exp_step;
                    if (mismatch) begin
                        err_hit  = 1'b1;
                        miss_nxt = miss_inc[3:0];
                        if (miss_inc == UNLOCK_W) begin
                            miss_nxt  = '0;
                            state_nxt = ST_SEARCH;
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    always_comb begin
        locked_nxt    = (state_nxt == ST_LOCKED);
        err_pulse_nxt = err_hit;
    end

    prbs8_sat_cnt u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (err_hit),
        .inc   (4'd1),
        .cnt   (err_cnt)
    );

    prbs8_sat_cnt u_bit_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (err_hit),
        .inc   (bit_errs),
        .cnt   (bit_err_cnt)
    );

endmodule
